// File: rtl/usb_seq_pkg.sv
// Shared types for the endpoint transfer sequencer: FSM states, result codes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package usb_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_SEND  = 2'd1,
    ST_OUT_RECV = 2'd2,
    ST_DONE     = 2'd3
  } seqState_t;

  // Handshake result reported once per transaction.
  localparam logic [1:0] RES_ACK   = 2'b00;
  localparam logic [1:0] RES_NAK   = 2'b01;
  localparam logic [1:0] RES_STALL = 2'b10;
  localparam logic [1:0] RES_ERR   = 2'b11;

  // Only endpoints 0..3 exist; any higher number is treated like a stalled endpoint.
  function automatic logic epIsStalled(input logic [3:0] endP, input logic [3:0] stallMask);
    return (endP[3:2] != 2'b00) || stallMask[endP[1:0]];
  endfunction

endpackage

// File: rtl/ep_fifo_sequencer.sv
// Per-token sequencer moving payload bytes between the SIE streams and the endpoint FIFOs.
// Latency: strobes are combinational in the active state; result pulses 1 cycle after the deciding cycle.
// Backpressure: IN side stalls on sieTxReady/TxFifoEmpty; OUT side cannot stall, overflow bytes are dropped and NAK'd.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   tokValid/tokEndP/tokIsIn   decoded token (1-cycle pulse), endpoint, direction
//   epStall                    per-endpoint stall flags
//   sieAbort                   abandon the current transaction, return to idle silently
//   currEndP, busy             selected endpoint (drives parent FIFO mux), transaction in progress
//   TxFifo*                    muxed Tx FIFO: pop strobe, FWFT head data, empty flag
//   RxFifo*                    muxed Rx FIFO: push strobe, write data, full flag
//   sieTx*                     IN payload stream to the SIE plus end-of-payload pulse
//   sieRx*                     OUT payload stream from the SIE (valid, data, end-of-packet)
//   resultValid/resultCode     per-transaction result pulse and held code
//   byteCount                  bytes moved in the current/last transaction
module ep_fifo_sequencer
  import usb_seq_pkg::*;
#(
  parameter int MAX_PKT = 64,
  parameter int CNT_W   = $clog2(MAX_PKT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tokValid,
  input  logic [3:0]       tokEndP,
  input  logic             tokIsIn,
  input  logic [3:0]       epStall,
  input  logic             sieAbort,
  output logic [3:0]       currEndP,
  output logic             busy,
  output logic             TxFifoREn,
  input  logic [7:0]       TxFifoData,
  input  logic             TxFifoEmpty,
  output logic             RxFifoWEn,
  output logic [7:0]       RxFifoData,
  input  logic             RxFifoFull,
  output logic [7:0]       sieTxData,
  output logic             sieTxValid,
  input  logic             sieTxReady,
  output logic             sieTxDone,
  input  logic [7:0]       sieRxData,
  input  logic             sieRxValid,
  input  logic             sieRxLast,
  output logic             resultValid,
  output logic [1:0]       resultCode,
  output logic [CNT_W-1:0] byteCount
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT);

  seqState_t  state;
  seqState_t  nextState;
  logic [1:0] doneCode;   // code decided in the cycle that heads to DONE
  logic [1:0] pendCode;   // code waiting to be published in DONE
  logic [1:0] lastCode;   // code of the last published result
  logic       ovf;        // at least one OUT byte was dropped this transaction

  logic tokAccept;
  logic tokStall;
  logic cntAtMax;
  logic txExit;
  logic rxDropNow;

  assign tokAccept = (state == ST_IDLE) && tokValid && !sieAbort;
  assign tokStall  = epIsStalled(tokEndP, epStall);
  assign cntAtMax  = (byteCount == MAX_CNT);
  // IN payload ends at a full packet, or at the first empty FIFO once something
  // was sent. An empty FIFO with nothing sent yet keeps waiting for data.
  assign txExit    = cntAtMax || (TxFifoEmpty && (byteCount != '0));
  assign rxDropNow = sieRxValid && (RxFifoFull || cntAtMax);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    doneCode  = RES_ERR;   // only states that can reach DONE override this
    case (state)
      ST_IDLE: begin
        if (tokValid) begin
          if (tokStall) begin
            nextState = ST_DONE;
            doneCode  = RES_STALL;
          end else if (tokIsIn) begin
            if (TxFifoEmpty) begin
              nextState = ST_DONE;
              doneCode  = RES_NAK;
            end else begin
              nextState = ST_IN_SEND;
            end
          end else begin
            nextState = ST_OUT_RECV;
          end
        end
      end
      ST_IN_SEND: begin
        if (txExit) begin
          nextState = ST_DONE;
          doneCode  = RES_ACK;
        end
      end
      ST_OUT_RECV: begin
        // A byte arriving with sieRxLast counts toward the overflow verdict.
        if (sieRxLast) begin
          nextState = ST_DONE;
          doneCode  = (ovf || rxDropNow) ? RES_NAK : RES_ACK;
        end
      end
      ST_DONE: begin
        nextState = ST_IDLE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
    if (sieAbort) begin
      nextState = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (all strobes suppressed in an abort cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state != ST_IDLE);
    TxFifoREn   = 1'b0;
    RxFifoWEn   = 1'b0;
    RxFifoData  = 8'h00;
    sieTxData   = 8'h00;
    sieTxValid  = 1'b0;
    sieTxDone   = 1'b0;
    resultValid = 1'b0;
    resultCode  = lastCode;
    case (state)
      ST_IN_SEND: begin
        sieTxData  = TxFifoData;
        sieTxValid = !TxFifoEmpty && (byteCount < MAX_CNT) && !sieAbort;
        TxFifoREn  = sieTxValid && sieTxReady;
        sieTxDone  = txExit && !sieAbort;
      end
      ST_OUT_RECV: begin
        RxFifoWEn  = sieRxValid && !rxDropNow && !sieAbort;
        RxFifoData = RxFifoWEn ? sieRxData : 8'h00;
      end
      ST_DONE: begin
        resultValid = !sieAbort;
        if (!sieAbort) begin
          resultCode = pendCode;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      currEndP  <= 4'd0;
      byteCount <= '0;
      ovf       <= 1'b0;
      pendCode  <= RES_ACK;
      lastCode  <= RES_ACK;
    end else begin
      if (tokAccept) begin
        currEndP  <= tokEndP;
        byteCount <= '0;
        ovf       <= 1'b0;
      end else if (TxFifoREn || RxFifoWEn) begin
        byteCount <= byteCount + 1'b1;
      end
      if ((state == ST_OUT_RECV) && rxDropNow && !sieAbort) begin
        ovf <= 1'b1;
      end
      if ((state != ST_DONE) && (nextState == ST_DONE)) begin
        pendCode <= doneCode;
      end
      // Keep the published code stable after the pulse.
      if ((state == ST_DONE) && !sieAbort) begin
        lastCode <= pendCode;
      end
    end
  end

endmodule
